// File: rtl/phantom_clock_gate.sv
// -----------------------------------------------------------------------------
// phantom_clock_gate
//
// Phantom real-time clock that sits behind the card's RAM/ROM decode. While
// idle it passes the RAM/ROM select straight through and watches write
// accesses for a 64-bit unlock pattern on A0. Once the pattern is seen, the
// next 64 RAM/ROM accesses are stolen from the memory. On each of them the
// host either shifts a bit out of a snapshot of the time register (A2=1) or
// shifts a bit in (A2=0). If the 64th stolen access is a write, the shifted-in
// value becomes the new time. The time register counts in BCD from a 100 Hz
// tick.
//
// Ports
//   C7M            in   system clock, all state changes on the rising edge
//   RES            in   synchronous active-high reset
//   nRAMROMCS      in   active-low RAM/ROM select from the card decode
//   ACC            in   one-cycle access strobe, one per bus cycle
//   A0             in   serial data-in bit
//   A2             in   1 = read access, 0 = write access
//   TICK           in   one-cycle 100 Hz strobe
//   RAMROMCSgb     out  gated select to the ROM/SRAM, active high
//   Q              out  serial data-out bit for D[0]
//   QOE            out  drive Q onto D[0]
//   dbg_clock_mode out  1 while the clock owns the bus (CLOCK state)
//   dbg_cnt        out  pattern-match count (idle) or access count (clock)
//   dbg_time       out  current time register
//
// Access qualification: an access counts only when ACC is high in the same
// cycle as nRAMROMCS is low. ACC with the select inactive is a sequencer fault
// and is ignored.
//
// Time layout {yr,mon,date,day,hr,min,sec,hsec}, one BCD byte each.
// -----------------------------------------------------------------------------
module phantom_clock_gate #(
   parameter logic [63:0] INIT_TIME = 64'h0001_0101_0000_0000,
   parameter logic [63:0] PATTERN   = 64'h5CA3_3AC5_5CA3_3AC5
) (
   input  logic        C7M,
   input  logic        RES,
   input  logic        nRAMROMCS,
   input  logic        ACC,
   input  logic        A0,
   input  logic        A2,
   input  logic        TICK,
   output logic        RAMROMCSgb,
   output logic        Q,
   output logic        QOE,
   output logic        dbg_clock_mode,
   output logic [5:0]  dbg_cnt,
   output logic [63:0] dbg_time
);

   typedef enum logic {IDLE = 1'b0, CLOCK = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] shadow_q, shadow_d;
   // The time register is never reset; it is loaded at configuration only.
   logic [63:0] time_q = INIT_TIME;
   logic [63:0] time_d;
   logic [63:0] time_tick;
   logic        acc_v;

   logic [8:0]  hs_r, se_r, mi_r, hr_r, dy_r;
   logic        c_sec, c_min, c_hr, c_day;
   logic [2:0]  tick_unused;

   // One BCD field step: {carry, next}. At max the field wraps to wrap_to and
   // carries. A units nibble of 9 or above (including invalid codes) rolls to
   // 0 and bumps the tens nibble, which likewise rolls to 0 from 9 or above.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                          input logic [7:0] max,
                                          input logic [7:0] wrap_to);
      logic [3:0] hi, lo;
      if (v == max) begin
         return {1'b1, wrap_to};
      end
      if (v[3:0] >= 4'd9) begin
         lo = 4'd0;
         hi = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         lo = v[3:0] + 4'd1;
         hi = v[7:4];
      end
      return {1'b0, hi, lo};
   endfunction

   // Tick arithmetic: hsec always steps, each higher field steps only when
   // every field below it wrapped. Date, month and year are never touched.
   always_comb begin
      hs_r  = bcd_inc(time_q[7:0],   8'h99, 8'h00);
      se_r  = bcd_inc(time_q[15:8],  8'h59, 8'h00);
      mi_r  = bcd_inc(time_q[23:16], 8'h59, 8'h00);
      // Only hr[5:0] counts; hr[7:6] are held as written.
      hr_r  = bcd_inc({2'b00, time_q[29:24]}, 8'h23, 8'h00);
      dy_r  = bcd_inc(time_q[39:32], 8'h07, 8'h01);
      c_sec = hs_r[8];
      c_min = c_sec & se_r[8];
      c_hr  = c_min & mi_r[8];
      c_day = c_hr  & hr_r[8];
      time_tick        = time_q;
      time_tick[7:0]   = hs_r[7:0];
      time_tick[15:8]  = c_sec ? se_r[7:0] : time_q[15:8];
      time_tick[23:16] = c_min ? mi_r[7:0] : time_q[23:16];
      time_tick[29:24] = c_hr  ? hr_r[5:0] : time_q[29:24];
      time_tick[39:32] = c_day ? dy_r[7:0] : time_q[39:32];
   end

   assign tick_unused = {hr_r[7:6], dy_r[8]};

   assign acc_v = ACC & ~nRAMROMCS;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      time_d   = TICK ? time_tick : time_q;
      if (acc_v) begin
         case (state_q)
            IDLE: begin
               // Any read or wrong bit restarts the hunt; the offending
               // access itself is not taken as a new first bit.
               if (!A2 && (A0 == PATTERN[cnt_q])) begin
                  if (cnt_q == 6'd63) begin
                     state_d  = CLOCK;
                     cnt_d    = 6'd0;
                     shadow_d = time_q;
                  end else begin
                     cnt_d = cnt_q + 6'd1;
                  end
               end else begin
                  cnt_d = 6'd0;
               end
            end
            CLOCK: begin
               shadow_d = {(A2 ? 1'b0 : A0), shadow_q[63:1]};
               cnt_d    = cnt_q + 6'd1;
               if (cnt_q == 6'd63) begin
                  state_d = IDLE;
                  cnt_d   = 6'd0;
                  // A commit overrides a coincident tick; reset aborts it.
                  if (!A2 && !RES) begin
                     time_d = shadow_d;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge C7M) begin
      if (RES) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         shadow_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
      time_q <= time_d;
   end

   assign RAMROMCSgb     = ~nRAMROMCS & (state_q == IDLE);
   assign Q              = shadow_q[0];
   assign QOE            = (state_q == CLOCK) & A2 & ~nRAMROMCS;
   assign dbg_clock_mode = (state_q == CLOCK);
   assign dbg_cnt        = cnt_q;
   assign dbg_time       = time_q;

endmodule

// File: tb/tb_phantom_clock_gate.sv
// -----------------------------------------------------------------------------
// tb_phantom_clock_gate
//
// Bench for phantom_clock_gate. A behavioural model tracks the unlock
// progress, the stolen-access count, the snapshot as a queue of bits and the
// time as plain decimal fields. A compare process checks every output against
// the model on each falling edge. Directed scenarios pin the model with
// hand-computed literals; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_phantom_clock_gate;

   localparam logic [63:0] PAT  = 64'h5CA3_3AC5_5CA3_3AC5;
   localparam logic [63:0] INIT = 64'h0001_0101_0000_0000;

   logic        C7M = 1'b0;
   logic        RES, nRAMROMCS, ACC, A0, A2, TICK;
   logic        RAMROMCSgb, Q, QOE, dbg_clock_mode;
   logic [5:0]  dbg_cnt;
   logic [63:0] dbg_time;

   phantom_clock_gate #(.INIT_TIME(INIT), .PATTERN(PAT)) dut (
      .C7M(C7M), .RES(RES), .nRAMROMCS(nRAMROMCS), .ACC(ACC), .A0(A0),
      .A2(A2), .TICK(TICK), .RAMROMCSgb(RAMROMCSgb), .Q(Q), .QOE(QOE),
      .dbg_clock_mode(dbg_clock_mode), .dbg_cnt(dbg_cnt), .dbg_time(dbg_time)
   );

   // ---------------- clock / reset ----------------
   always #5 C7M = ~C7M;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   bit rnd_tick = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_clock;
   int         m_prog, m_taken;
   logic [0:0] exp_q[$];          // snapshot bits, element 0 is the next bit out
   int         t_hs, t_se, t_mi, t_hr, t_hrtop, t_day, t_date, t_mon, t_yr;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [63:0] m_time();
      logic [7:0] hrb;
      hrb = to_bcd(t_hr);
      hrb[7:6] = 2'(t_hrtop);
      return {to_bcd(t_yr), to_bcd(t_mon), to_bcd(t_date), to_bcd(t_day),
              hrb, to_bcd(t_mi), to_bcd(t_se), to_bcd(t_hs)};
   endfunction

   task automatic set_time(input logic [63:0] v);
      t_hs    = from_bcd(v[7:0]);
      t_se    = from_bcd(v[15:8]);
      t_mi    = from_bcd(v[23:16]);
      t_hr    = from_bcd({2'b00, v[29:24]});
      t_hrtop = int'(v[31:30]);
      t_day   = from_bcd(v[39:32]);
      t_date  = from_bcd(v[47:40]);
      t_mon   = from_bcd(v[55:48]);
      t_yr    = from_bcd(v[63:56]);
   endtask

   task automatic m_tick();
      t_hs++;
      if (t_hs == 100) begin
         t_hs = 0; t_se++;
         if (t_se == 60) begin
            t_se = 0; t_mi++;
            if (t_mi == 60) begin
               t_mi = 0; t_hr++;
               if (t_hr == 24) begin
                  t_hr = 0;
                  t_day = (t_day == 7) ? 1 : t_day + 1;
               end
            end
         end
      end
   endtask

   task automatic model_step();
      bit          do_commit;
      logic [63:0] cv;
      do_commit = 1'b0;
      cv = '0;
      if (RES) begin
         m_clock = 1'b0; m_prog = 0; m_taken = 0;
         exp_q.delete();
         for (int i = 0; i < 64; i++) exp_q.push_back(1'b0);
      end else if (ACC && !nRAMROMCS) begin
         if (!m_clock) begin
            if (!A2 && (A0 == PAT[m_prog])) begin
               m_prog++;
               if (m_prog == 64) begin
                  m_prog = 0; m_clock = 1'b1; m_taken = 0;
                  cv = m_time();
                  exp_q.delete();
                  for (int i = 0; i < 64; i++) exp_q.push_back(cv[i]);
               end
            end else begin
               m_prog = 0;
            end
         end else begin
            void'(exp_q.pop_front());
            exp_q.push_back(A2 ? 1'b0 : A0);
            m_taken++;
            if (m_taken == 64) begin
               m_clock = 1'b0; m_taken = 0;
               if (!A2) begin
                  do_commit = 1'b1;
                  for (int i = 0; i < 64; i++) cv[i] = exp_q[i];
               end
            end
         end
      end
      if (do_commit) set_time(cv);
      else if (TICK) m_tick();
   endtask

   always @(posedge C7M) model_step();

   // ---------------- compare process ----------------
   logic e_gb, e_qoe, e_q, e_cm;
   logic [5:0] e_cnt;
   always @(negedge C7M) begin
      if (chk_en) begin
         e_gb  = !nRAMROMCS && !m_clock;
         e_qoe = m_clock && A2 && !nRAMROMCS;
         e_q   = exp_q[0];
         e_cm  = m_clock;
         e_cnt = 6'(m_clock ? m_taken : m_prog);
         chk("gb", 64'(RAMROMCSgb), 64'(e_gb));
         chk("q", 64'(Q), 64'(e_q));
         chk("qoe", 64'(QOE), 64'(e_qoe));
         chk("state", 64'(dbg_clock_mode), 64'(e_cm));
         chk("cnt", 64'(dbg_cnt), 64'(e_cnt));
         chk("time", dbg_time, m_time());
      end
   end

   // ---------------- driver tasks ----------------
   logic s_q, s_gb;

   task automatic gap();
      ACC = 1'b0;
      TICK = rnd_tick && ($urandom_range(0, 15) == 0);
      nRAMROMCS = 1'($urandom_range(0, 1));
      A2 = 1'($urandom_range(0, 1));
      A0 = 1'($urandom_range(0, 1));
      @(posedge C7M); #1;
      TICK = 1'b0;
   endtask

   task automatic access(input logic a2, input logic a0, input logic tk);
      nRAMROMCS = 1'b0; ACC = 1'b1; A2 = a2; A0 = a0; TICK = tk;
      @(negedge C7M);
      s_q = Q; s_gb = RAMROMCSgb;
      @(posedge C7M); #1;
      gap();
   endtask

   task automatic fault();
      nRAMROMCS = 1'b1; ACC = 1'b1;
      A2 = 1'($urandom_range(0, 1)); A0 = 1'($urandom_range(0, 1));
      @(posedge C7M); #1;
      ACC = 1'b0;
   endtask

   task automatic tick_once();
      nRAMROMCS = 1'b1; ACC = 1'b0; TICK = 1'b1;
      @(posedge C7M); #1;
      TICK = 1'b0;
   endtask

   task automatic pulse_reset();
      RES = 1'b1; ACC = 1'b0; TICK = 1'b0; nRAMROMCS = 1'b1;
      @(posedge C7M); #1;
      RES = 1'b0;
   endtask

   task automatic unlock();
      for (int i = 0; i < 64; i++) access(1'b0, PAT[i], 1'b0);
   endtask

   task automatic write_time(input logic [63:0] v, input logic tk_last);
      unlock();
      for (int i = 0; i < 64; i++) access(1'b0, v[i], (i == 63) ? tk_last : 1'b0);
   endtask

   task automatic reads_64(output logic [63:0] v, output logic gb_seen);
      gb_seen = 1'b0;
      v = '0;
      for (int i = 0; i < 64; i++) begin
         access(1'b1, 1'b0, 1'b0);
         v[i] = s_q;
         if (s_gb) gb_seen = 1'b1;
      end
   endtask

   function automatic logic [63:0] rand_time();
      logic [7:0] hrb;
      hrb = to_bcd(int'($urandom_range(0, 23)));
      hrb[7:6] = 2'($urandom_range(0, 3));
      return {to_bcd(int'($urandom_range(0, 99))), to_bcd(int'($urandom_range(1, 12))),
              to_bcd(int'($urandom_range(1, 31))), to_bcd(int'($urandom_range(1, 7))),
              hrb, to_bcd(int'($urandom_range(0, 59))), to_bcd(int'($urandom_range(55, 59))),
              to_bcd(int'($urandom_range(90, 99)))};
   endfunction

   // ---------------- stimulus ----------------
   logic [63:0] rv;
   logic        gbs;
   int          kind, k;

   initial begin
      t_yr = 0; t_mon = 1; t_date = 1; t_day = 1;
      t_hr = 0; t_hrtop = 0; t_mi = 0; t_se = 0; t_hs = 0;
      m_clock = 1'b0; m_prog = 0; m_taken = 0;
      for (int i = 0; i < 64; i++) exp_q.push_back(1'b0);

      RES = 1'b1; nRAMROMCS = 1'b1; ACC = 1'b0; A0 = 1'b0; A2 = 1'b0; TICK = 1'b0;
      repeat (2) @(posedge C7M);
      #1;
      RES = 1'b0;
      chk_en = 1'b1;

      // reset state
      nRAMROMCS = 1'b0; A2 = 1'b1;
      #2;
      chk("rst_time", dbg_time, INIT);
      chk("rst_gb", 64'(RAMROMCSgb), 64'd1);
      chk("rst_q", 64'(Q), 64'd0);
      chk("rst_qoe", 64'(QOE), 64'd0);
      chk("rst_cnt", 64'(dbg_cnt), 64'd0);
      @(posedge C7M); #1;
      nRAMROMCS = 1'b1;

      // 1: unlock, snapshot equals the time register
      unlock();
      chk("t1_state", 64'(dbg_clock_mode), 64'd1);
      reads_64(rv, gbs);
      chk("t1_snapshot", rv, INIT);
      chk("t1_gb_gated", 64'(gbs), 64'd0);

      // 2: read a known time LSB first, select restored on the 65th access
      write_time(64'h2401_0103_2359_5999, 1'b0);
      unlock();
      reads_64(rv, gbs);
      chk("t2_read", rv, 64'h2401_0103_2359_5999);
      chk("t2_gb_gated", 64'(gbs), 64'd0);
      access(1'b1, 1'b0, 1'b0);
      chk("t2_gb_65th", 64'(s_gb), 64'd1);

      // 3: write commits, then one tick
      write_time(64'h9912_3107_1530_0000, 1'b0);
      chk("t3_commit", dbg_time, 64'h9912_3107_1530_0000);
      tick_once();
      chk("t3_tick", dbg_time, 64'h9912_3107_1530_0001);

      // 4: full rollover incl. day 7 -> 1
      write_time(64'h2506_1507_2359_5999, 1'b0);
      tick_once();
      chk("t4_rollover", dbg_time, 64'h2506_1501_0000_0000);

      // 5: wrong bit 40 aborts, read at bit 10 aborts
      for (int i = 0; i < 40; i++) access(1'b0, PAT[i], 1'b0);
      access(1'b0, ~PAT[40], 1'b0);
      chk("t5_bad_cnt", 64'(dbg_cnt), 64'd0);
      chk("t5_bad_state", 64'(dbg_clock_mode), 64'd0);
      unlock();
      chk("t5_unlock", 64'(dbg_clock_mode), 64'd1);
      reads_64(rv, gbs);
      for (int i = 0; i < 10; i++) access(1'b0, PAT[i], 1'b0);
      chk("t5_cnt10", 64'(dbg_cnt), 64'd10);
      access(1'b1, 1'b0, 1'b0);
      chk("t5_read_cnt", 64'(dbg_cnt), 64'd0);

      // 6: reset mid-write aborts; commit beats a coincident tick
      unlock();
      for (int i = 0; i < 30; i++) access(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      pulse_reset();
      chk("t6_rst_state", 64'(dbg_clock_mode), 64'd0);
      chk("t6_rst_time", dbg_time, 64'h2506_1501_0000_0000);
      write_time(64'h1211_0506_1122_3344, 1'b1);
      chk("t6_commit_tick", dbg_time, 64'h1211_0506_1122_3344);

      // randomized sessions
      rnd_tick = 1'b1;
      for (int s = 0; s < 40; s++) begin
         access(1'b1, 1'b0, 1'b0);
         kind = $urandom_range(0, 4);
         case (kind)
            0: for (int i = 0; i < 20; i++) begin
                  if ($urandom_range(0, 4) == 0) fault();
                  else access(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
               end
            1: write_time(rand_time(), 1'($urandom_range(0, 1)));
            2: begin unlock(); reads_64(rv, gbs); end
            3: begin
                  unlock();
                  for (int i = 0; i < 63; i++)
                     access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                  access(1'b1, 1'b0, 1'b0);
               end
            default: begin
                  unlock();
                  k = $urandom_range(1, 63);
                  for (int i = 0; i < k; i++) access(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                  pulse_reset();
               end
         endcase
      end

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
